// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if
//   Bus bundle between the program sequencer, the CPU core and the
//   program loader.
//   cpu_in / cpu_load / cpu_s : instruction word, IR load strobe, start strobe
//   cpu_w                     : core idle flag (1 = core waiting)
//   prog_we/prog_addr/prog_data : instruction-store write port
//   master = sequencer side, slave = core/loader side.
interface instr_sequencer_if #(
  parameter int AW = 5
) ();
  logic [15:0]   cpu_in;
  logic          cpu_load;
  logic          cpu_s;
  logic          cpu_w;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;

  modport master (
    output cpu_in, cpu_load, cpu_s,
    input  cpu_w, prog_we, prog_addr, prog_data
  );

  modport slave (
    input  cpu_in, cpu_load, cpu_s,
    output cpu_w, prog_we, prog_addr, prog_data
  );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Self-running program executor for a single-instruction CPU core.
//   Fetches 16-bit words from a small instruction store, hands each one to
//   the core (load strobe, then start strobe) and waits for the core to
//   return to idle before advancing. Stops on a HALT word (bits [15:13] all
//   ones), after the last store address, or when the core stays busy too
//   long (watchdog).
// Ports
//   clk, reset   : clock, asynchronous active-low reset
//   start        : begin a run from address 0 (only honoured in IDLE/DONE)
//   bus          : core handshake and instruction-store write port
//   pc           : address of the current instruction
//   busy/done/err: run in progress / run finished / finished by watchdog
//   instr_count  : instructions completed in this run (saturating)
module instr_sequencer #(
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 256,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  instr_sequencer_if.master   bus,
  output logic [AW-1:0]       pc,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [15:0]         instr_count
);

  localparam int WCW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CHECK = 3'd2,
    S_LOAD  = 3'd3,
    S_START = 3'd4,
    S_WAIT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  function automatic logic is_halt(input logic [15:0] word);
    return (word[15:13] == 3'b111);
  endfunction

  logic [15:0]    mem [DEPTH];

  state_t         state_q,    state_d;
  logic [15:0]    instr_q,    instr_d;
  logic [15:0]    cpu_in_q,   cpu_in_d;
  logic           cpu_load_q, cpu_load_d;
  logic           cpu_s_q,    cpu_s_d;
  logic [AW-1:0]  pc_q,       pc_d;
  logic           busy_q,     busy_d;
  logic           done_q,     done_d;
  logic           err_q,      err_d;
  logic [15:0]    cnt_q,      cnt_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;

  logic           prog_ok_s;

  // The store may only be rewritten while no run is in progress.
  assign prog_ok_s = (state_q == S_IDLE) || (state_q == S_DONE);

  // Instruction store write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (bus.prog_we && prog_ok_s) begin
      mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  // Next-state and next-output logic for the sequencing FSM.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    cpu_in_d   = cpu_in_q;
    cpu_load_d = 1'b0;
    cpu_s_d    = 1'b0;
    pc_d       = pc_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    wait_cnt_d = wait_cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pc_d    = '0;
          cnt_d   = 16'd0;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end else begin
          state_d = state_q;
        end
      end
      S_FETCH: begin
        instr_d = mem[pc_q];
        state_d = S_CHECK;
      end
      S_CHECK: begin
        // cpu_in only changes here, so it is stable from LOAD through WAIT.
        if (is_halt(instr_q)) begin
          state_d = S_DONE;
        end else begin
          cpu_in_d   = instr_q;
          cpu_load_d = 1'b1;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        cpu_s_d = 1'b1;
        state_d = S_START;
      end
      S_START: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + WCW'(1);
        // On the first WAIT cycle cpu_w still reflects the core before it
        // saw the start strobe, so it cannot mean completion yet.
        if (bus.cpu_w && (wait_cnt_q != '0)) begin
          if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end else begin
            cnt_d = cnt_q;
          end
          if (pc_q == AW'(DEPTH - 1)) begin
            state_d = S_DONE;
          end else begin
            pc_d    = pc_q + AW'(1);
            state_d = S_FETCH;
          end
        end else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered copies of the next state.
    busy_d = (state_d == S_FETCH) || (state_d == S_CHECK) || (state_d == S_LOAD) ||
             (state_d == S_START) || (state_d == S_WAIT);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      instr_q    <= 16'd0;
      cpu_in_q   <= 16'd0;
      cpu_load_q <= 1'b0;
      cpu_s_q    <= 1'b0;
      pc_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= 16'd0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      cpu_in_q   <= cpu_in_d;
      cpu_load_q <= cpu_load_d;
      cpu_s_q    <= cpu_s_d;
      pc_q       <= pc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign bus.cpu_in   = cpu_in_q;
  assign bus.cpu_load = cpu_load_q;
  assign bus.cpu_s    = cpu_s_q;
  assign pc           = pc_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign instr_count  = cnt_q;

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Program sequencer that sits directly upstream of the CPU core. It holds a small instruction store and feeds one 16-bit instruction at a time into the core's `in`/`load`/`s` inputs. It waits on the core's `w` (wait/idle) flag before advancing the program counter. It turns the single-instruction core into a self-running program executor, with halt detection, end-of-memory stop and a watchdog on stuck instructions.

## Interface
- `DEPTH`, 32, number of 16-bit instruction words (power of 2, ≥2); `AW = $clog2(DEPTH)`
- `TIMEOUT`, 256, maximum cycles spent in WAIT before the error stop (≥2)
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a program run from address 0; sampled only in IDLE or DONE
- `prog_we`  in  1  instruction-store write enable
- `prog_addr`  in  AW  instruction-store write address
- `prog_data`  in  16  instruction-store write data
- `cpu_w`  in  1  core wait flag (1 = core idle in its Wait state)
- `cpu_in`  out  16  instruction to core (registered)
- `cpu_load`  out  1  core instruction-register load strobe
- `cpu_s`  out  1  core start strobe
- `pc`  out  AW  address of current instruction
- `busy`  out  1  run in progress
- `done`  out  1  run finished (level, held in DONE)
- `err`  out  1  run ended by watchdog
- `instr_count`  out  16  instructions completed this run, saturating at 16'hFFFF

## Operation
- Instruction store: DEPTH×16, synchronous write, not reset (contents survive reset). Writes are honoured only in IDLE or DONE; ignored otherwise.
- HALT encoding: bits [15:13] == 3'b111. It is never sent to the core.
- States:
  - IDLE: busy=0. If `start`, then pc←0, instr_count←0, err←0, go to FETCH.
  - FETCH: instr_q←mem[pc], go to CHECK.
  - CHECK: if instr_q is HALT, go to DONE. Otherwise cpu_in←instr_q and go to LOAD.
  - LOAD: cpu_load=1 for exactly one cycle, go to START.
  - START: cpu_s=1 for exactly one cycle, wait_cnt←0, go to WAIT.
  - WAIT: wait_cnt increments each cycle.
    - If cpu_w=1 and wait_cnt≥1: instr_count increments (saturating). Then if pc==DEPTH-1 go to DONE; else pc←pc+1 and go to FETCH.
    - Else if wait_cnt==TIMEOUT-1: err←1, go to DONE.
  - DONE: done=1, busy=0, pc and instr_count hold. If `start`, behave as in IDLE.
- busy=1 in FETCH, CHECK, LOAD, START and WAIT.
- The wait_cnt≥1 rule ignores the stale cpu_w=1 present on the edge right after cpu_s.
- cpu_in changes only on the CHECK→LOAD transition and is stable from LOAD through WAIT.
- Simultaneous `start` and `prog_we` in IDLE/DONE: both are honoured. The write lands before the first FETCH.
- `start` while busy: ignored.
- Reset (async, any state): state=IDLE; cpu_in=0, cpu_load=0, cpu_s=0, pc=0, busy=0, done=0, err=0, instr_count=0, wait_cnt=0, instr_q=0.

## Timing
- Edge 0 samples start=1 in IDLE. The following cycles are:
  - cycle 1: FETCH
  - cycle 2: CHECK
  - cycle 3: LOAD (cpu_load=1, cpu_in valid)
  - cycle 4: START (cpu_s=1)
  - cycle 5 onward: WAIT
- The core latches the instruction on the edge ending cycle 3 and sees s on the edge ending cycle 4.
- Per-instruction overhead: 4 cycles (FETCH, CHECK, LOAD, START) plus core execution time plus 1.
- From the WAIT edge that sees cpu_w=1, the next cpu_load is 3 cycles later.
- HALT stop: done=1 in the cycle after CHECK.
- Watchdog stop: done=err=1 exactly TIMEOUT cycles after entering WAIT.
- `done`, `err`, `busy` and `pc` are registered outputs with no combinational path from inputs.

## Test plan
- Async reset: assert reset=0 mid-WAIT, with no clock edge. All outputs go to 0 immediately. After release, the FSM is in IDLE and a previously written mem[0] is still readable via a new run.
- Normal run: write mem[0..3] = 16'hD105, 16'hD203, 16'hA0A2, 16'hE000. Use a core model that drops w for 3 cycles after s. Expect:
  - cpu_load pulses with cpu_in = D105, D203, A0A2 in that order
  - no pulse for E000
  - done=1, err=0, pc=3, instr_count=3
- Handshake cycle check: start at edge 0. Expect cpu_load high only in cycle 3, cpu_s high only in cycle 4, and cpu_in constant through WAIT.
- Stale-w filtering: the core model leaves w=1 for one cycle after s, then drops it for 2 cycles. Expect no advance until w returns, and instr_count increments once per instruction.
- Watchdog: TIMEOUT=8 and the core model holds w=0 forever after s. Expect err=1 and done=1 exactly 8 cycles after WAIT entry, with instr_count=0 and pc=0.
- End of memory and protection: DEPTH=4 with no HALT words. Expect 4 loads, then done with pc=3 and instr_count=4. During the run, prog_we to addr 0 and a start pulse are both ignored: mem[0] is unchanged and the run does not restart.
